pipeline_ctrl: RTL and testbench

Central sequencing controller for the 5-stage pipelined CPU.
- Owns the per-stage write enables (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) and the IF/ID and ID/EX flush/bubble controls.
- Merges three concerns: start/run sequencing, load-use stall, and branch/jump flush. It also freezes the whole pipeline while data memory holds off an access.
- Provides saturating performance counters (cycles, stalls, flushes, memory-wait cycles) and a memory-timeout error state.

---
 rtl/pipeline_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Central sequencing controller for a 5-stage pipelined CPU. It owns the
//   per-stage write enables and the IF/ID flush / ID/EX bubble controls. It
//   merges run sequencing, load-use stalls, branch/jump flushes and a
//   memory-wait freeze. It also keeps saturating performance counters and a
//   sticky memory-timeout error.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i                 level-sensitive run request
//   ifid_rs_i, ifid_rt_i    source registers of the instruction in ID
//   idex_memread_i          instruction in EX is a load
//   idex_rt_i               destination register of the load in EX
//   branch_taken_i, jump_i  control transfer resolved in ID
//   dmem_req_i, dmem_ack_i  data-memory access request / completion
//   *_we_o, ifid_flush_o, idex_bubble_o   pipeline register controls
//   running_o, err_o        run status and sticky timeout error
//   *_cnt_o                 saturating performance counters
module pipeline_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic             branch_taken_i,
  input  logic             jump_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             pc_we_o,
  output logic             ifid_we_o,
  output logic             ifid_flush_o,
  output logic             idex_we_o,
  output logic             idex_bubble_o,
  output logic             exmem_we_o,
  output logic             memwb_we_o,
  output logic             running_o,
  output logic             err_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] memwait_cnt_o
);

  // Wait counter must be able to hold the value TIMEOUT itself.
  localparam int                WAIT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_ERROR    = 2'd3
  } state_t;

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait;
  logic              r_err;
  logic [CNT_W-1:0]  r_cycle_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic [CNT_W-1:0]  r_memwait_cnt;

  logic w_active;
  logic w_hazard;
  logic w_freeze;
  logic w_redirect;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  assign w_active   = (r_state == S_RUN) || (r_state == S_MEM_WAIT);
  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign w_hazard   = idex_memread_i && (idex_rt_i != 5'd0) &&
                      ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
  assign w_freeze   = dmem_req_i && !dmem_ack_i;
  assign w_redirect = branch_taken_i || jump_i;

  // Output decode: freeze > load-use hazard > branch/jump > normal flow.
  always_comb begin
    pc_we_o       = 1'b0;
    ifid_we_o     = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_we_o     = 1'b0;
    idex_bubble_o = 1'b0;
    exmem_we_o    = 1'b0;
    memwb_we_o    = 1'b0;
    if (rst_i || !w_active) begin
      pc_we_o = 1'b0;
    end else if (w_freeze) begin
      pc_we_o = 1'b0;
    end else if (w_hazard) begin
      // Hold PC and IF/ID; insert a bubble into EX while older stages drain.
      idex_we_o     = 1'b1;
      idex_bubble_o = 1'b1;
      exmem_we_o    = 1'b1;
      memwb_we_o    = 1'b1;
    end else if (w_redirect) begin
      pc_we_o      = 1'b1;
      ifid_we_o    = 1'b1;
      ifid_flush_o = 1'b1;
      idex_we_o    = 1'b1;
      exmem_we_o   = 1'b1;
      memwb_we_o   = 1'b1;
    end else begin
      pc_we_o    = 1'b1;
      ifid_we_o  = 1'b1;
      idex_we_o  = 1'b1;
      exmem_we_o = 1'b1;
      memwb_we_o = 1'b1;
    end
  end

  // Sequencing state, memory-wait timer, error flag and performance counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_wait        <= '0;
      r_err         <= 1'b0;
      r_cycle_cnt   <= '0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
      r_memwait_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN, S_MEM_WAIT: begin
          r_cycle_cnt <= sat_inc(r_cycle_cnt);
          if (w_freeze) begin
            r_memwait_cnt <= sat_inc(r_memwait_cnt);
          end else if (w_hazard) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
          end else if (w_redirect) begin
            r_flush_cnt <= sat_inc(r_flush_cnt);
          end else begin
            r_cycle_cnt <= sat_inc(r_cycle_cnt);
          end
          // Dropping the run request wins over everything else, including
          // a freeze that has reached the timeout.
          if (!start_i) begin
            r_state <= S_IDLE;
            r_wait  <= '0;
          end else if (w_freeze) begin
            if (r_wait == WAIT_MAX) begin
              r_state <= S_ERROR;
              r_err   <= 1'b1;
            end else begin
              r_state <= S_MEM_WAIT;
              r_wait  <= r_wait + WAIT_W'(1);
            end
          end else begin
            r_state <= S_RUN;
            r_wait  <= '0;
          end
        end
        S_ERROR: begin
          r_state <= S_ERROR;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign running_o     = w_active && !rst_i;
  assign err_o         = r_err;
  assign cycle_cnt_o   = r_cycle_cnt;
  assign stall_cnt_o   = r_stall_cnt;
  assign flush_cnt_o   = r_flush_cnt;
  assign memwait_cnt_o = r_memwait_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl. Every cycle the expected outputs for the
// stimulus being driven are computed from a behavioural reference and pushed
// to a scoreboard queue; at the falling edge the entry is popped and compared
// against the DUT. Directed milestone checks use hand-derived constants.
module tb_pipeline_ctrl;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 4;

  logic clk_i = 1'b0;
  logic rst_i, start_i, idex_memread_i, branch_taken_i, jump_i, dmem_req_i, dmem_ack_i;
  logic [4:0] ifid_rs_i, ifid_rt_i, idex_rt_i;
  logic pc_we_o, ifid_we_o, ifid_flush_o, idex_we_o, idex_bubble_o, exmem_we_o, memwb_we_o;
  logic running_o, err_o;
  logic [CNT_W-1:0] cycle_cnt_o, stall_cnt_o, flush_cnt_o, memwait_cnt_o;

  pipeline_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i),
    .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
    .branch_taken_i(branch_taken_i), .jump_i(jump_i),
    .dmem_req_i(dmem_req_i), .dmem_ack_i(dmem_ack_i),
    .pc_we_o(pc_we_o), .ifid_we_o(ifid_we_o), .ifid_flush_o(ifid_flush_o),
    .idex_we_o(idex_we_o), .idex_bubble_o(idex_bubble_o),
    .exmem_we_o(exmem_we_o), .memwb_we_o(memwb_we_o),
    .running_o(running_o), .err_o(err_o),
    .cycle_cnt_o(cycle_cnt_o), .stall_cnt_o(stall_cnt_o),
    .flush_cnt_o(flush_cnt_o), .memwait_cnt_o(memwait_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Enable vector order: {pc, ifid, ifid_flush, idex, idex_bubble, exmem, memwb}
  typedef struct packed {
    logic [6:0]       en;
    logic             run;
    logic             err;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] stl;
    logic [CNT_W-1:0] fl;
    logic [CNT_W-1:0] mw;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: 0 IDLE, 1 RUN, 2 MEM_WAIT, 3 ERROR
  int               m_state;
  int               m_wait;
  logic             m_err;
  logic [CNT_W-1:0] m_cyc, m_stl, m_fl, m_mw;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [CNT_W-1:0] sat8(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 8'd1;
  endfunction

  function automatic logic ref_hazard();
    return idex_memread_i && (idex_rt_i != 5'd0) &&
           ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    logic act;
    e = '0;
    act = ((m_state == 1) || (m_state == 2)) && !rst_i;
    if (act) begin
      if (dmem_req_i && !dmem_ack_i)         e.en = 7'b0000000;
      else if (ref_hazard())                 e.en = 7'b0001111;
      else if (branch_taken_i || jump_i)     e.en = 7'b1111011;
      else                                   e.en = 7'b1101011;
    end
    e.run = act;
    e.err = m_err;
    e.cyc = m_cyc;
    e.stl = m_stl;
    e.fl  = m_fl;
    e.mw  = m_mw;
    return e;
  endfunction

  task automatic model_step();
    logic frz;
    frz = dmem_req_i && !dmem_ack_i;
    if (rst_i) begin
      m_state = 0; m_wait = 0; m_err = 1'b0;
      m_cyc = '0; m_stl = '0; m_fl = '0; m_mw = '0;
    end else if (m_state == 0) begin
      if (start_i) m_state = 1;
    end else if (m_state == 1 || m_state == 2) begin
      m_cyc = sat8(m_cyc);
      if (frz)                            m_mw  = sat8(m_mw);
      else if (ref_hazard())              m_stl = sat8(m_stl);
      else if (branch_taken_i || jump_i)  m_fl  = sat8(m_fl);
      if (!start_i) begin
        m_state = 0; m_wait = 0;
      end else if (frz) begin
        if (m_wait == TIMEOUT) begin
          m_state = 3; m_err = 1'b1;
        end else begin
          m_state = 2; m_wait++;
        end
      end else begin
        m_state = 1; m_wait = 0;
      end
    end
  endtask

  // One clock: push expectation, compare at the falling edge, advance model.
  task automatic cyc();
    exp_t e;
    sb_q.push_back(model_out());
    @(negedge clk_i);
    e = sb_q.pop_front();
    check_val("enables", {25'd0, pc_we_o, ifid_we_o, ifid_flush_o, idex_we_o,
                          idex_bubble_o, exmem_we_o, memwb_we_o}, {25'd0, e.en});
    check_val("running", {31'd0, running_o}, {31'd0, e.run});
    check_val("err", {31'd0, err_o}, {31'd0, e.err});
    check_val("cycle_cnt", {24'd0, cycle_cnt_o}, {24'd0, e.cyc});
    check_val("stall_cnt", {24'd0, stall_cnt_o}, {24'd0, e.stl});
    check_val("flush_cnt", {24'd0, flush_cnt_o}, {24'd0, e.fl});
    check_val("memwait_cnt", {24'd0, memwait_cnt_o}, {24'd0, e.mw});
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; idex_memread_i = 1'b0; branch_taken_i = 1'b0;
    jump_i = 1'b0; dmem_req_i = 1'b0; dmem_ack_i = 1'b0;
    ifid_rs_i = 5'd0; ifid_rt_i = 5'd0; idex_rt_i = 5'd0;
    m_state = 0; m_wait = 0; m_err = 1'b0;
    m_cyc = '0; m_stl = '0; m_fl = '0; m_mw = '0;
    @(posedge clk_i);
    #1;

    // Reset and idle
    cyc();
    rst_i = 1'b0;
    cyc();
    check_val("rst_cycle_cnt", {24'd0, cycle_cnt_o}, 32'd0);
    check_val("rst_err", {31'd0, err_o}, 32'd0);
    check_val("rst_running", {31'd0, running_o}, 32'd0);

    // Start and 10 plain RUN cycles
    start_i = 1'b1;
    cyc();
    check_val("start_running", {31'd0, running_o}, 32'd1);
    cycles(10);
    check_val("run10_cycle_cnt", {24'd0, cycle_cnt_o}, 32'd10);
    check_val("run10_stall_cnt", {24'd0, stall_cnt_o}, 32'd0);

    // Load-use hazard on rt, then the same with destination register 0
    idex_memread_i = 1'b1; idex_rt_i = 5'd8; ifid_rt_i = 5'd8;
    cyc();
    check_val("hazard_stall_cnt", {24'd0, stall_cnt_o}, 32'd1);
    idex_rt_i = 5'd0; ifid_rt_i = 5'd0;
    cyc();
    check_val("r0_no_stall", {24'd0, stall_cnt_o}, 32'd1);
    idex_memread_i = 1'b0;

    // Jump flush, then hazard (rs match) together with a taken branch
    jump_i = 1'b1;
    cyc();
    jump_i = 1'b0;
    check_val("jump_flush_cnt", {24'd0, flush_cnt_o}, 32'd1);
    idex_memread_i = 1'b1; idex_rt_i = 5'd8; ifid_rs_i = 5'd8; branch_taken_i = 1'b1;
    cyc();
    check_val("hb_flush_cnt", {24'd0, flush_cnt_o}, 32'd1);
    check_val("hb_stall_cnt", {24'd0, stall_cnt_o}, 32'd2);
    idex_memread_i = 1'b0;
    cyc();
    branch_taken_i = 1'b0;
    check_val("branch_reeval_flush", {24'd0, flush_cnt_o}, 32'd2);

    // Memory freeze for 3 cycles, released by ack
    dmem_req_i = 1'b1; dmem_ack_i = 1'b0;
    cycles(3);
    dmem_ack_i = 1'b1;
    cyc();
    dmem_req_i = 1'b0; dmem_ack_i = 1'b0;
    check_val("freeze_memwait_cnt", {24'd0, memwait_cnt_o}, 32'd3);
    check_val("freeze_back_run", {31'd0, running_o}, 32'd1);

    // Drop start: one more RUN-decoded cycle, then idle with counting stopped
    start_i = 1'b0;
    cycles(3);
    check_val("stop_running", {31'd0, running_o}, 32'd0);
    check_val("stop_cycle_cnt", {24'd0, cycle_cnt_o}, 32'd20);

    // Memory timeout: 5th consecutive freeze cycle enters ERROR
    start_i = 1'b1;
    cyc();
    dmem_req_i = 1'b1;
    cycles(4);
    check_val("pre_timeout_err", {31'd0, err_o}, 32'd0);
    cyc();
    check_val("timeout_err", {31'd0, err_o}, 32'd1);
    cycles(3);
    check_val("error_memwait_frozen", {24'd0, memwait_cnt_o}, 32'd8);
    check_val("error_cycle_frozen", {24'd0, cycle_cnt_o}, 32'd25);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0; dmem_req_i = 1'b0; start_i = 1'b0;
    cyc();
    check_val("post_rst_err", {31'd0, err_o}, 32'd0);
    check_val("post_rst_memwait", {24'd0, memwait_cnt_o}, 32'd0);
    check_val("post_rst_cycle", {24'd0, cycle_cnt_o}, 32'd0);

    // Counter saturation with continuous jumps
    start_i = 1'b1;
    cyc();
    jump_i = 1'b1;
    cycles(260);
    check_val("sat_flush_cnt", {24'd0, flush_cnt_o}, 32'd255);
    check_val("sat_cycle_cnt", {24'd0, cycle_cnt_o}, 32'd255);
    jump_i = 1'b0; start_i = 1'b0;
    cycles(2);
    check_val("final_idle", {31'd0, running_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
